// File: rtl/enemy_spawner_pkg.sv
// Shared types and screen constants for the enemy spawner and its neighbours.
package enemy_spawner_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int IDX_W    = 3;

   typedef enum logic {IDLE, CAPTURE} spawn_state_t;

   typedef struct packed {
      logic       act;
      logic [9:0] x;
      logic [8:0] y;
   } enemy_t;

endpackage

// File: rtl/enemy_spawner_if.sv
// Bundle between enemy_spawner, enemy_x_gen and the draw/collision logic.
interface enemy_spawner_if
   import enemy_spawner_pkg::*;
#(
   parameter int N_ENEMY = 4
) ();

   // next/spawned pulse high for exactly one cycle per spawn; x_in is sampled on
   // the edge that ends the pulse, the same edge on which enemy_x_gen advances.
   logic                 frame_tick;
   logic                 spawn_en;
   logic [9:0]           x_in;
   logic [N_ENEMY-1:0]   kill;
   logic                 next;
   logic                 spawned;
   logic                 escaped;
   logic [N_ENEMY-1:0]   active;
   logic [9:0]           ex [N_ENEMY];
   logic [8:0]           ey [N_ENEMY];
   spawn_state_t         state;

   modport slave (
      input  frame_tick, spawn_en, x_in, kill,
      output next, spawned, escaped, active, ex, ey, state
   );

   modport master (
      output frame_tick, spawn_en, x_in, kill,
      input  next, spawned, escaped, active, ex, ey, state
   );

endinterface

// File: rtl/enemy_spawner_lowest_free_enc.sv
// Finds the lowest-index free enemy slot; purely combinational.
module lowest_free_enc
   import enemy_spawner_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     active_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan downward so the last hit written is the lowest free index.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!active_i[i]) begin
            found_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/enemy_spawner.sv
// Enemy slot pool: periodic spawning from enemy_x_gen, per-frame descent,
// retirement on kill or on leaving the bottom of the screen.
module enemy_spawner
   import enemy_spawner_pkg::*;
#(
   parameter int N_ENEMY      = 4,
   parameter int SPAWN_PERIOD = 60,
   parameter int SPEED        = 2,
   parameter int Y_MAX        = SCREEN_H
) (
   input  logic            clk,
   input  logic            reset,
   enemy_spawner_if.slave  bus
);

   localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

   spawn_state_t      state_q;
   logic [IDX_W-1:0]  sel_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              pending_q;
   logic              next_q;
   logic              escaped_q, escaped_d;
   enemy_t            slot_q [N_ENEMY];
   enemy_t            slot_d [N_ENEMY];
   logic [9:0]        y_step [N_ENEMY];
   logic [N_ENEMY-1:0] act_vec;
   logic              free_found;
   logic [IDX_W-1:0]  free_idx;

   for (genvar g = 0; g < N_ENEMY; g++) begin : g_slot
      assign act_vec[g]    = slot_q[g].act;
      assign y_step[g]     = {1'b0, slot_q[g].y} + 10'(SPEED);
      assign bus.active[g] = slot_q[g].act;
      assign bus.ex[g]     = slot_q[g].x;
      assign bus.ey[g]     = slot_q[g].y;
   end

   assign bus.next    = next_q;
   assign bus.spawned = next_q;
   assign bus.escaped = escaped_q;
   assign bus.state   = state_q;

   lowest_free_enc #(.N(N_ENEMY)) u_enc (
      .active_i (act_vec),
      .found_o  (free_found),
      .idx_o    (free_idx)
   );

   // A new period request is kept even if it lands on the edge ending CAPTURE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         next_q    <= 1'b0;
      end else begin
         next_q <= 1'b0;
         if (bus.spawn_en && bus.frame_tick)
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         if (!bus.spawn_en)
            pending_q <= 1'b0;
         else if (bus.frame_tick && cnt_q == CNT_LAST)
            pending_q <= 1'b1;
         else if (state_q == CAPTURE)
            pending_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pending_q && free_found) begin
                  sel_q   <= free_idx;
                  state_q <= CAPTURE;
                  next_q  <= 1'b1;
               end
            end
            CAPTURE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      slot_d    = slot_q;
      escaped_d = 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
         if (state_q == CAPTURE && sel_q == IDX_W'(i)) begin
            slot_d[i].act = 1'b1;
            slot_d[i].x   = bus.x_in;
            slot_d[i].y   = '0;
         end else if (slot_q[i].act) begin
            if (bus.kill[i]) begin
               slot_d[i].act = 1'b0;
            end else if (bus.frame_tick) begin
               if (y_step[i] >= 10'(Y_MAX)) begin
                  slot_d[i].act = 1'b0;
                  escaped_d     = 1'b1;
               end else begin
                  slot_d[i].y = y_step[i][8:0];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_ENEMY; i++) slot_q[i] <= '0;
         escaped_q <= 1'b0;
      end else begin
         slot_q    <= slot_d;
         escaped_q <= escaped_d;
      end
   end

endmodule
